// File: rtl/simple_mem_pkg.sv
// simple_mem_pkg: shared types and constants for the simple_proc data-memory
// responder. The bus shape (width/addrsize) used by the write-buffer entry is
// fixed here; the top-level parameters default to these values.
// Optional feature macro: SIMPLE_MEM_MMIO_EN (write-counter register at the
// top word address).
package simple_mem_pkg;

    localparam int SM_WIDTH    = 32;
    localparam int SM_ADDRSIZE = 8;
    localparam int SM_MEMSIZE  = 1 << SM_ADDRSIZE;

    // Top word of the address space; doubles as the counter register when
    // SIMPLE_MEM_MMIO_EN is defined.
    localparam logic [SM_ADDRSIZE-1:0] MMIO_CNT_ADDR = {SM_ADDRSIZE{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_t;

    // One posted write waiting to be committed to the array.
    typedef struct packed {
        logic                   valid;
        logic [SM_ADDRSIZE-1:0] addr;
        logic [SM_WIDTH-1:0]    data;
    } wbuf_entry_t;

    function automatic logic is_mmio_addr(input logic [SM_ADDRSIZE-1:0] addr);
        return (addr == MMIO_CNT_ADDR);
    endfunction

endpackage

// File: rtl/simple_mem_wbuf.sv
// simple_mem_wbuf: write-side front end of the memory responder.
// - suppresses the repeated writes simple_proc issues while it holds we high
// - holds one posted write for exactly one cycle before it commits
// - provides the forwarding compare for reads that hit the pending write
// - keeps the accepted-write counter (only with SIMPLE_MEM_MMIO_EN)
module simple_mem_wbuf
    import simple_mem_pkg::*;
#(
    parameter int width    = SM_WIDTH,
    parameter int addrsize = SM_ADDRSIZE
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                accept_en,
    input  logic                mem_we,
    input  logic [addrsize-1:0] mem_addr,
    input  logic [width-1:0]    mem_wdata,
    output wbuf_entry_t         wbuf,
    output logic                fwd_hit,
    output logic [width-1:0]    fwd_data
`ifdef SIMPLE_MEM_MMIO_EN
    ,
    output logic [width-1:0]    wr_count
`endif
);

    logic                prev_we_r;
    logic                last_valid_r;
    logic [addrsize-1:0] last_addr_r;
    logic [width-1:0]    last_data_r;
    wbuf_entry_t         wbuf_r;
    logic                fresh_s;
    logic                accept_s;

    // Classify the current write as new or as a repeat of the held request
    always_comb begin
        fresh_s  = 1'b0;
        accept_s = 1'b0;
        if (!prev_we_r || !last_valid_r ||
            (mem_addr != last_addr_r) || (mem_wdata != last_data_r)) begin
            fresh_s = 1'b1;
        end else begin
            fresh_s = 1'b0;
        end
        if (accept_en && mem_we && fresh_s) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Remember the raw strobe and the last accepted write for duplicate detection
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev_we_r    <= 1'b0;
            last_valid_r <= 1'b0;
            last_addr_r  <= {addrsize{1'b0}};
            last_data_r  <= {width{1'b0}};
        end else begin
            prev_we_r <= mem_we;
            if (accept_s) begin
                last_valid_r <= 1'b1;
                last_addr_r  <= mem_addr;
                last_data_r  <= mem_wdata;
            end
        end
    end

    // Posted write entry: loaded on acceptance, committed by the top on the next edge
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wbuf_r.valid <= 1'b0;
            wbuf_r.addr  <= {addrsize{1'b0}};
            wbuf_r.data  <= {width{1'b0}};
        end else begin
            wbuf_r.valid <= accept_s;
            if (accept_s) begin
                wbuf_r.addr <= mem_addr;
                wbuf_r.data <= mem_wdata;
            end
        end
    end

    // Forwarding compare: a read of the pending address sees the buffered data
    always_comb begin
        fwd_hit  = wbuf_r.valid && (wbuf_r.addr == mem_addr);
        fwd_data = wbuf_r.data;
    end

`ifdef SIMPLE_MEM_MMIO_EN
    logic [width-1:0] wr_count_r;

    // Accepted-write counter, wraps at the bus width; cleared only by reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_count_r <= {width{1'b0}};
        end else if (accept_s) begin
            wr_count_r <= wr_count_r + {{(width-1){1'b0}}, 1'b1};
        end
    end

    assign wr_count = wr_count_r;
`endif

    assign wbuf = wbuf_r;

endmodule

// File: rtl/simple_mem_resp.sv
// simple_mem_resp: synchronous data-memory slave for the simple_proc bus.
// After reset the array is zeroed one word per cycle (mem_ready low), then
// writes are posted through simple_mem_wbuf and reads return registered data
// one cycle after the address, forwarded from the pending write when it hits.
// Optional feature macro: SIMPLE_MEM_MMIO_EN -- the top word address becomes a
// read-only register returning the accepted-write count.
module simple_mem_resp
    import simple_mem_pkg::*;
#(
    parameter int width    = SM_WIDTH,
    parameter int addrsize = SM_ADDRSIZE,
    parameter int memsize  = 1 << addrsize
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                mem_we,
    input  logic [addrsize-1:0] mem_addr,
    input  logic [width-1:0]    mem_wdata,
    output logic [width-1:0]    mem_rdata,
    output logic                mem_ready
);

    localparam logic [addrsize-1:0] LAST_PTR = addrsize'(memsize - 1);

    mem_state_t          state_r;
    mem_state_t          state_next_s;
    logic [addrsize-1:0] clr_ptr_r;
    logic                clr_en_s;
    logic                bus_en_s;

    logic [width-1:0]    mem_r [memsize];
    logic [width-1:0]    rdata_r;
    logic [width-1:0]    rd_mux_s;
    logic                ready_r;
    logic                commit_s;

    wbuf_entry_t         wbuf_s;
    logic                fwd_hit_s;
    logic [width-1:0]    fwd_data_s;
`ifdef SIMPLE_MEM_MMIO_EN
    logic [width-1:0]    wr_count_s;
`endif

    simple_mem_wbuf #(
        .width    (width),
        .addrsize (addrsize)
    ) u_wbuf (
        .clk       (clk),
        .nrst      (nrst),
        .accept_en (bus_en_s),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .wbuf      (wbuf_s),
        .fwd_hit   (fwd_hit_s),
        .fwd_data  (fwd_data_s)
`ifdef SIMPLE_MEM_MMIO_EN
        ,
        .wr_count  (wr_count_s)
`endif
    );

    // State register and clear pointer; reset restarts the clear from word 0
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {addrsize{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (clr_en_s) begin
                clr_ptr_r <= clr_ptr_r + {{(addrsize-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next state: leave the clear once the last word is being zeroed
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_ptr_r == LAST_PTR) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: state_next_s = ST_READY;
            default:  state_next_s = ST_CLEAR;
        endcase
    end

    // State decode: clearing owns the array, ready hands it to the bus
    always_comb begin
        clr_en_s = 1'b0;
        bus_en_s = 1'b0;
        case (state_r)
            ST_CLEAR: clr_en_s = 1'b1;
            ST_READY: bus_en_s = 1'b1;
            default: begin
                clr_en_s = 1'b0;
                bus_en_s = 1'b0;
            end
        endcase
    end

    // Commit qualifier: the counter register has no backing storage
    always_comb begin
        commit_s = 1'b0;
`ifdef SIMPLE_MEM_MMIO_EN
        if (wbuf_s.valid && !is_mmio_addr(wbuf_s.addr)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
`else
        if (wbuf_s.valid) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
`endif
    end

    // Array write port; during reset the pending entry is dropped
    always_ff @(posedge clk) begin
        if (nrst) begin
            if (clr_en_s) begin
                mem_r[clr_ptr_r] <= {width{1'b0}};
            end else if (commit_s) begin
                mem_r[wbuf_s.addr] <= wbuf_s.data;
            end
        end
    end

    // Read source select: counter register, pending write, then array
    always_comb begin
        rd_mux_s = mem_r[mem_addr];
`ifdef SIMPLE_MEM_MMIO_EN
        if (is_mmio_addr(mem_addr)) begin
            rd_mux_s = wr_count_s;
        end else if (fwd_hit_s) begin
            rd_mux_s = fwd_data_s;
        end else begin
            rd_mux_s = mem_r[mem_addr];
        end
`else
        if (fwd_hit_s) begin
            rd_mux_s = fwd_data_s;
        end else begin
            rd_mux_s = mem_r[mem_addr];
        end
`endif
    end

    // Read data register: zero while clearing, loaded on reads, held across writes
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rdata_r <= {width{1'b0}};
        end else if (clr_en_s) begin
            rdata_r <= {width{1'b0}};
        end else if (!mem_we) begin
            rdata_r <= rd_mux_s;
        end
    end

    // Ready flag registered in step with the state transition
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_READY);
        end
    end

    assign mem_rdata = rdata_r;
    assign mem_ready = ready_r;

endmodule
